// File: rtl/pipe_dispatcher_pkg.sv
// Shared widths, datapath constants and the request record for the series-evaluation front end.
package pipe_dispatcher_pkg;

    localparam int X_W           = 8;
    localparam int N_W           = 3;
    localparam int LOOP_N_THRESH = 4;
    localparam int STAGES        = 4;
    localparam int REQ_W         = X_W + N_W;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [N_W-1:0] n;
    } req_t;

endpackage

// File: rtl/pipe_dispatcher_sync_fifo.sv
// Synchronous FIFO with an occupancy counter; full/empty come from the count, pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pipe_dispatcher.sv
// Feeds buffered (x, n) requests into the series datapath, one load per ready cycle, and tracks in-flight work.
module pipe_dispatcher
    import pipe_dispatcher_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] in_x,
    input  logic [N_W-1:0] in_n,
    input  logic           flush_req,
    input  logic           dp_ready,
    input  logic           dp_valid,
    output logic           dp_load,
    output logic [X_W-1:0] dp_x,
    output logic [N_W-1:0] dp_n,
    output logic           dp_inuse,
    output logic           dp_flush,
    output logic [2:0]     inflight,
    output logic           idle
);

    // Handshake: a request transfers on a cycle where in_valid & in_ready are both high;
    // the datapath takes one entry (real or bubble) on every cycle dp_load is high.

    req_t                   wr_req;
    req_t                   head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   fifo_clr;
    logic                   push;
    logic                   pop;
    logic                   issue;
    logic                   retire;
    logic                   err;

    assign wr_req   = '{x: in_x, n: in_n};
    assign fifo_clr = rst | flush_req;
    assign push     = in_valid & in_ready & ~fifo_clr;

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (fifo_clr),
        .push  (push),
        .pop   (pop),
        .wdata (wr_req),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    assign in_ready = ~fifo_full;
    assign idle     = fifo_empty & (inflight == '0);

    // Loading a bubble on empty ready cycles keeps a stale input register from re-injecting after a loop-back slot.
    assign dp_load  = dp_ready & ~rst & ~flush_req;
    assign dp_inuse = ~fifo_empty & ~rst;
    assign dp_x     = dp_inuse ? head.x : '0;
    assign dp_n     = dp_inuse ? head.n : '0;
    assign dp_flush = flush_req & ~rst;
    assign pop      = dp_load & dp_inuse;

    assign issue  = dp_load & dp_inuse;
    assign retire = dp_valid & (inflight != '0);

    always_ff @(posedge clk) begin
        if (fifo_clr) begin
            inflight <= '0;
        end else begin
            case ({issue, retire})
                2'b10: if (inflight < 3'(MAX_INFLIGHT)) inflight <= inflight + 3'd1;
                2'b01: inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // A result with nothing outstanding is dropped but remembered.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (dp_valid && inflight == '0 && !flush_req) begin
            err <= 1'b1;
        end
    end

    a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
        inflight <= 3'(MAX_INFLIGHT));
    a_occupancy_bound: assert property (@(posedge clk) disable iff (rst)
        occupancy <= ($clog2(DEPTH)+1)'(DEPTH));

endmodule

// File: tb/tb_pipe_dispatcher.sv
// Directed vector table plus randomized traffic checked against a queue-based model of the dispatcher.
module tb_pipe_dispatcher;

    localparam int DEPTH = 4;
    localparam int MAXF  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [2:0] in_n;
    logic       flush_req;
    logic       dp_ready;
    logic       dp_valid;
    logic       dp_load;
    logic [7:0] dp_x;
    logic [2:0] dp_n;
    logic       dp_inuse;
    logic       dp_flush;
    logic [2:0] inflight;
    logic       idle;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       iv;
        logic [7:0] x;
        logic [2:0] n;
        logic       fl;
        logic       rdy;
        logic       vld;
        logic       e_ir;
        logic       e_ld;
        logic       e_iu;
        logic [7:0] e_x;
        logic [2:0] e_n;
        logic       e_fl;
        logic [2:0] e_inf;
        logic       e_idle;
    } vec_t;

    vec_t tbl[$];

    // model state: pending requests as {x, n} and outstanding count
    logic [10:0] exp_q[$];
    int          m_infl;

    // clock/reset block
    always #5 clk = ~clk;

    pipe_dispatcher #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAXF)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_n      (in_n),
        .flush_req (flush_req),
        .dp_ready  (dp_ready),
        .dp_valid  (dp_valid),
        .dp_load   (dp_load),
        .dp_x      (dp_x),
        .dp_n      (dp_n),
        .dp_inuse  (dp_inuse),
        .dp_flush  (dp_flush),
        .inflight  (inflight),
        .idle      (idle)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: apply inputs just after the falling edge so outputs settle before the next rising edge
    task automatic drive(input logic r, input logic iv, input logic [7:0] x, input logic [2:0] n,
                         input logic fl, input logic rdy, input logic vld);
        @(negedge clk);
        rst = r; in_valid = iv; in_x = x; in_n = n;
        flush_req = fl; dp_ready = rdy; dp_valid = vld;
        #1;
    endtask

    // scoreboard: compare against the model's view of this cycle, then advance the model
    task automatic model_cycle(input logic r, input logic iv, input logic [7:0] x, input logic [2:0] n,
                               input logic fl, input logic rdy, input logic vld);
        bit  e_ready, e_load, e_inuse;
        int  e_x, e_n;
        e_ready = (exp_q.size() < DEPTH);
        e_load  = rdy && !r && !fl;
        e_inuse = !r && (exp_q.size() != 0);
        e_x     = e_inuse ? int'(exp_q[0][10:3]) : 0;
        e_n     = e_inuse ? int'(exp_q[0][2:0])  : 0;
        chk("rnd_in_ready", int'(in_ready), int'(e_ready));
        chk("rnd_dp_load",  int'(dp_load),  int'(e_load));
        chk("rnd_dp_inuse", int'(dp_inuse), int'(e_inuse));
        chk("rnd_dp_x",     int'(dp_x),     e_x);
        chk("rnd_dp_n",     int'(dp_n),     e_n);
        chk("rnd_dp_flush", int'(dp_flush), int'(fl && !r));
        chk("rnd_inflight", int'(inflight), m_infl);
        chk("rnd_idle",     int'(idle),     int'(exp_q.size() == 0 && m_infl == 0));
        if (r || fl) begin
            exp_q.delete();
            m_infl = 0;
        end else begin
            if (e_load && e_inuse) begin
                void'(exp_q.pop_front());
                m_infl = m_infl + 1;
            end
            if (vld && m_infl > 0 && !(e_load && e_inuse && m_infl == 1 && 0)) begin
                m_infl = m_infl - 1;
            end
            if (m_infl > MAXF) m_infl = MAXF;
            if (iv && e_ready) exp_q.push_back({x, n});
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_n = '0;
        flush_req = 1'b0; dp_ready = 1'b1; dp_valid = 1'b0;

        // reset: load, bubble marker and flush are all held low, even with flush_req asserted
        drive(1, 1, 8'hAA, 3'd2, 0, 1, 0);
        chk("rst_dp_load",  int'(dp_load),  0);
        chk("rst_dp_inuse", int'(dp_inuse), 0);
        chk("rst_dp_flush", int'(dp_flush), 0);
        drive(1, 0, 8'h00, 3'd0, 1, 1, 0);
        chk("rst_flush_held", int'(dp_flush), 0);
        chk("rst_dp_load2",   int'(dp_load),  0);

        //           iv  x     n  fl rdy vld | ir ld iu x     n  fl inf idle
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0,  1, 1, 0, 8'h00, 0, 0, 0, 1}); // idle bubble
        tbl.push_back('{1, 8'h20, 3, 0, 1, 0,  1, 1, 0, 8'h00, 0, 0, 0, 1}); // push, no bypass
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0,  1, 1, 1, 8'h20, 3, 0, 0, 0}); // issued t+1
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0,  1, 1, 0, 8'h00, 0, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 1,  1, 1, 0, 8'h00, 0, 0, 1, 0}); // result returns
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0,  1, 1, 0, 8'h00, 0, 0, 0, 1});
        tbl.push_back('{1, 8'h11, 1, 0, 0, 0,  1, 0, 0, 8'h00, 0, 0, 0, 1}); // backpressure fill
        tbl.push_back('{1, 8'h22, 2, 0, 0, 0,  1, 0, 1, 8'h11, 1, 0, 0, 0});
        tbl.push_back('{1, 8'h33, 5, 0, 0, 0,  1, 0, 1, 8'h11, 1, 0, 0, 0});
        tbl.push_back('{1, 8'h44, 7, 0, 0, 0,  1, 0, 1, 8'h11, 1, 0, 0, 0});
        tbl.push_back('{1, 8'h55, 6, 0, 0, 0,  0, 0, 1, 8'h11, 1, 0, 0, 0}); // full, 5th refused
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0,  0, 1, 1, 8'h11, 1, 0, 0, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0,  1, 1, 1, 8'h22, 2, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 0,  1, 0, 1, 8'h33, 5, 0, 2, 0}); // loop gap
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0,  1, 1, 1, 8'h33, 5, 0, 2, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 1,  1, 1, 1, 8'h44, 7, 0, 3, 0}); // issue + valid
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0,  1, 1, 0, 8'h00, 0, 0, 3, 0}); // E was dropped
        tbl.push_back('{1, 8'h66, 0, 0, 0, 0,  1, 0, 0, 8'h00, 0, 0, 3, 0});
        tbl.push_back('{1, 8'h77, 4, 0, 0, 0,  1, 0, 1, 8'h66, 0, 0, 3, 0});
        tbl.push_back('{1, 8'h0F, 2, 0, 1, 0,  1, 1, 1, 8'h66, 0, 0, 3, 0}); // push+pop at 2
        tbl.push_back('{1, 8'h01, 1, 0, 0, 0,  1, 0, 1, 8'h77, 4, 0, 4, 0});
        tbl.push_back('{1, 8'h02, 2, 1, 1, 0,  1, 0, 1, 8'h77, 4, 1, 4, 0}); // flush, push lost
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0,  1, 1, 0, 8'h00, 0, 0, 0, 1});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 1,  1, 1, 0, 8'h00, 0, 0, 0, 1}); // stray valid

        foreach (tbl[i]) begin
            drive(0, tbl[i].iv, tbl[i].x, tbl[i].n, tbl[i].fl, tbl[i].rdy, tbl[i].vld);
            chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_ir));
            chk($sformatf("v%0d_dp_load", i),  int'(dp_load),  int'(tbl[i].e_ld));
            chk($sformatf("v%0d_dp_inuse", i), int'(dp_inuse), int'(tbl[i].e_iu));
            chk($sformatf("v%0d_dp_x", i),     int'(dp_x),     int'(tbl[i].e_x));
            chk($sformatf("v%0d_dp_n", i),     int'(dp_n),     int'(tbl[i].e_n));
            chk($sformatf("v%0d_dp_flush", i), int'(dp_flush), int'(tbl[i].e_fl));
            chk($sformatf("v%0d_inflight", i), int'(inflight), int'(tbl[i].e_inf));
            chk($sformatf("v%0d_idle", i),     int'(idle),     int'(tbl[i].e_idle));
        end

        // stray valid leaves the sticky error flag set
        drive(0, 0, 8'h00, 0, 0, 1, 0);
        chk("err_sticky", int'(dut.err), 1);
        chk("err_no_underflow", int'(inflight), 0);

        // saturation: six issues with no results returned
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 8'(k + 1), 3'(k), 0, 1, 0);
        end
        drive(0, 0, 8'h00, 0, 0, 1, 0);
        drive(0, 0, 8'h00, 0, 0, 1, 0);
        chk("inflight_saturate", int'(inflight), MAXF);

        // randomized traffic against the model, starting from a reset
        drive(1, 0, 8'h00, 0, 0, 1, 0);
        exp_q.delete();
        m_infl = 0;
        for (int c = 0; c < 600; c++) begin
            logic       r, iv, fl, rdy, vld;
            logic [7:0] x;
            logic [2:0] n;
            r   = ($urandom_range(0, 99) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            iv  = ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 2) != 0);
            vld = (m_infl > 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
            x   = 8'($urandom);
            n   = 3'($urandom);
            drive(r, iv, x, n, fl, rdy, vld);
            model_cycle(r, iv, x, n, fl, rdy, vld);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
